cdb_arb: RTL and testbench

CDB_ARB -- requirements
Module: cdb_arb

---
 rtl/cdb_arb_pkg.sv | 16 +
 rtl/cdb_fifo2.sv | 53 +++++
 rtl/cdb_arb.sv | 107 ++++++++++
 tb/tb_cdb_arb.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_arb_pkg.sv
// Shared types for the common-data-bus arbiter: ROB id / data widths and the broadcast packet.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cdb_arb_pkg;

  localparam int ROB_SIZE_CLOG = 5;
  localparam int DATA_LEN      = 32;
  localparam int N_REQ_DEFAULT = 4;

  // One functional-unit result as it travels through the buffer and onto the bus.
  typedef struct packed {
    logic [ROB_SIZE_CLOG-1:0] robid;
    logic [DATA_LEN-1:0]      data;
  } cdb_pkt_t;

endpackage

// File: rtl/cdb_fifo2.sv
// Two-entry result buffer for one CDB requester; head is always the oldest entry.
// Latency: a pushed entry is visible at head the cycle after the push edge (no bypass).
// Backpressure: the owner must not push when count==2 nor pop when count==0.
module cdb_fifo2
  import cdb_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       push,
  input  cdb_pkt_t   push_pkt,
  input  logic       pop,
  output cdb_pkt_t   head,
  output logic [1:0] count
);

  cdb_pkt_t mem [2];
  logic     wr_ptr;
  logic     rd_ptr;

  // Storage write; contents need no reset because count gates their visibility.
  always_ff @(posedge clk) begin
    if (push && !rst && !clear) begin
      mem[wr_ptr] <= push_pkt;
    end
  end

  // Pointer and occupancy bookkeeping; reset and clear drop everything held.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + 2'(push) - 2'(pop);
    end
  end

  assign head = mem[rd_ptr];

  // Guard the owner's side of the contract.
  a_no_overflow : assert property (@(posedge clk) disable iff (rst || clear)
    !(push && count == 2'd2));
  a_no_underflow : assert property (@(posedge clk) disable iff (rst || clear)
    !(pop && count == 2'd0));

endmodule

// File: rtl/cdb_arb.sv
// Common-data-bus arbiter: per-requester 2-deep buffers, round-robin grant, registered broadcast.
// Latency: push in cycle N -> arbitrated in N+1 -> on cdb_* in N+2.
// Backpressure: req_rdy[i] drops when buffer i holds 2 entries, and during flush or reset.
module cdb_arb
  import cdb_arb_pkg::*;
#(
  parameter int N_REQ      = N_REQ_DEFAULT,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 flush,
  input  logic [N_REQ-1:0]                     req_v,
  output logic [N_REQ-1:0]                     req_rdy,
  input  logic [N_REQ-1:0][ROB_SIZE_CLOG-1:0]  req_robid,
  input  logic [N_REQ-1:0][DATA_LEN-1:0]       req_data,
  output logic                                 cdb_v,
  output logic [ROB_SIZE_CLOG-1:0]             cdb_robid,
  output logic [DATA_LEN-1:0]                  cdb_data,
  output logic [$clog2(N_REQ)-1:0]             cdb_src
);

  localparam int             SRC_W     = $clog2(N_REQ);
  localparam int             SUM_W     = SRC_W + 1;
  localparam logic [1:0]     DEPTH_CNT = 2'(FIFO_DEPTH);
  localparam logic [SUM_W-1:0] N_REQ_W = SUM_W'(N_REQ);
  localparam logic [SRC_W-1:0] LAST_IDX = SRC_W'(N_REQ - 1);

  cdb_pkt_t             in_pkt     [N_REQ];
  cdb_pkt_t             fifo_head  [N_REQ];
  logic [1:0]           fifo_count [N_REQ];
  logic [N_REQ-1:0]     push;
  logic [N_REQ-1:0]     pop;
  logic [N_REQ-1:0]     nonempty;

  logic [SRC_W-1:0]     rr_ptr;
  logic [SRC_W-1:0]     winner;
  logic                 grant;
  logic [SUM_W-1:0]     search_sum;
  logic [SRC_W-1:0]     search_idx;

  for (genvar g = 0; g < N_REQ; g++) begin : g_req
    // Ready depends only on registered occupancy plus the flush/reset controls.
    assign req_rdy[g]  = (fifo_count[g] < DEPTH_CNT) && !flush && !rst;
    assign push[g]     = req_v[g] && req_rdy[g];
    assign pop[g]      = grant && (winner == SRC_W'(g)) && !flush && !rst;
    assign nonempty[g] = (fifo_count[g] != 2'd0);
    assign in_pkt[g]   = '{robid: req_robid[g], data: req_data[g]};

    cdb_fifo2 u_fifo (
      .clk      (clk),
      .rst      (rst),
      .clear    (flush),
      .push     (push[g]),
      .push_pkt (in_pkt[g]),
      .pop      (pop[g]),
      .head     (fifo_head[g]),
      .count    (fifo_count[g])
    );
  end

  // Round-robin search: first non-empty buffer at or after rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    grant      = 1'b0;
    winner     = '0;
    search_sum = '0;
    search_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      search_sum = {1'b0, rr_ptr} + SUM_W'(k);
      if (search_sum >= N_REQ_W) begin
        search_sum = search_sum - N_REQ_W;
      end
      search_idx = search_sum[SRC_W-1:0];
      if (!grant && nonempty[search_idx]) begin
        grant  = 1'b1;
        winner = search_idx;
      end
    end
  end

  // Broadcast register and pointer update; payload holds its last value while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_v     <= 1'b0;
      cdb_robid <= '0;
      cdb_data  <= '0;
      cdb_src   <= '0;
      rr_ptr    <= '0;
    end else if (flush) begin
      cdb_v  <= 1'b0;
      rr_ptr <= '0;
    end else if (grant) begin
      cdb_v     <= 1'b1;
      cdb_robid <= fifo_head[winner].robid;
      cdb_data  <= fifo_head[winner].data;
      cdb_src   <= winner;
      rr_ptr    <= (winner == LAST_IDX) ? '0 : winner + 1'b1;
    end else begin
      cdb_v <= 1'b0;
    end
  end

  // At most one buffer is drained per cycle, and a flush always silences the next cycle.
  a_single_pop : assert property (@(posedge clk) disable iff (rst) $onehot0(pop));
  a_flush_quiet : assert property (@(posedge clk) disable iff (rst) flush |=> !cdb_v);

endmodule

// File: tb/tb_cdb_arb.sv
// Self-checking bench for cdb_arb: per-requester scoreboard queues plus an expected grant order.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Backpressure: the driver holds req_v and its payload until req_rdy accepts it.
module tb_cdb_arb;
  import cdb_arb_pkg::*;

  localparam int N = 4;

  logic                                clk = 1'b0;
  logic                                rst;
  logic                                flush;
  logic [N-1:0]                        req_v;
  logic [N-1:0]                        req_rdy;
  logic [N-1:0][ROB_SIZE_CLOG-1:0]     req_robid;
  logic [N-1:0][DATA_LEN-1:0]          req_data;
  logic                                cdb_v;
  logic [ROB_SIZE_CLOG-1:0]            cdb_robid;
  logic [DATA_LEN-1:0]                 cdb_data;
  logic [1:0]                          cdb_src;

  int                       n_chk     = 0;
  int                       n_fail    = 0;
  int                       bcast_cnt = 0;
  cdb_pkt_t                 sbq [N][$];
  logic [1:0]               exp_src [$];
  logic [ROB_SIZE_CLOG-1:0] next_robid = 5'd1;
  cdb_pkt_t                 mon_pkt;
  logic [1:0]               mon_src;
  int                       rem [N];
  bit                       need_new [N];

  cdb_arb #(.N_REQ(N), .FIFO_DEPTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .req_v     (req_v),
    .req_rdy   (req_rdy),
    .req_robid (req_robid),
    .req_data  (req_data),
    .cdb_v     (cdb_v),
    .cdb_robid (cdb_robid),
    .cdb_data  (cdb_data),
    .cdb_src   (cdb_src)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a fresh payload on every requester selected by mask.
  task automatic drive(input logic [N-1:0] mask);
    for (int i = 0; i < N; i++) begin
      req_v[i] = mask[i];
      if (mask[i]) begin
        req_robid[i] = next_robid;
        req_data[i]  = $urandom;
        next_robid   = next_robid + 5'd1;
      end
    end
  endtask

  function automatic bit sb_empty();
    for (int i = 0; i < N; i++) begin
      if (sbq[i].size() != 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic clear_sb();
    for (int i = 0; i < N; i++) sbq[i].delete();
    exp_src.delete();
  endtask

  task automatic drain(input string tag, input int max_cycles);
    bit done = 1'b0;
    for (int k = 0; k < max_cycles; k++) begin
      @(negedge clk);
      if (sb_empty()) begin
        done = 1'b1;
        break;
      end
    end
    check(tag, 64'(done), 64'(1));
  endtask

  // Scoreboard: compare each broadcast against its requester's queue, then log new handshakes.
  always @(negedge clk) begin
    if (!rst) begin
      if (cdb_v) begin
        bcast_cnt++;
        if (sbq[cdb_src].size() == 0) begin
          check("sb_unexpected_bcast", 64'(1), 64'(0));
        end else begin
          mon_pkt = sbq[cdb_src].pop_front();
          check("sb_robid", 64'(cdb_robid), 64'(mon_pkt.robid));
          check("sb_data", 64'(cdb_data), 64'(mon_pkt.data));
        end
        if (exp_src.size() != 0) begin
          mon_src = exp_src.pop_front();
          check("src_order", 64'(cdb_src), 64'(mon_src));
        end
      end
      for (int i = 0; i < N; i++) begin
        if (req_v[i] && req_rdy[i]) begin
          sbq[i].push_back('{robid: req_robid[i], data: req_data[i]});
        end
      end
    end
  end

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    req_v     = '0;
    req_robid = '0;
    req_data  = '0;

    // Reset state
    step();
    step();
    @(negedge clk);
    check("rst_cdb_v", 64'(cdb_v), 64'(0));
    check("rst_robid", 64'(cdb_robid), 64'(0));
    check("rst_data", 64'(cdb_data), 64'(0));
    check("rst_src", 64'(cdb_src), 64'(0));
    check("rst_rdy", 64'(req_rdy), 64'(0));
    step();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_rdy", 64'(req_rdy), 64'hF);

    // Round robin from rr_ptr=0 with every buffer loaded twice
    step();
    drive(4'b1111);
    for (int k = 0; k < 8; k++) exp_src.push_back(2'(k % 4));
    step();
    drive(4'b1111);
    step();
    req_v = '0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("rr_v", 64'(cdb_v), 64'(1));
      step();
    end
    @(negedge clk);
    check("rr_idle", 64'(cdb_v), 64'(0));
    check("rr_order_used", 64'(exp_src.size()), 64'(0));

    // Single requester: visible exactly two cycles after the push
    step();
    req_v        = 4'b0100;
    req_robid[2] = 5'd5;
    req_data[2]  = 32'hDEAD;
    exp_src.push_back(2'd2);
    @(negedge clk);
    check("single_c0_v", 64'(cdb_v), 64'(0));
    step();
    req_v = '0;
    @(negedge clk);
    check("single_c1_v", 64'(cdb_v), 64'(0));
    step();
    @(negedge clk);
    check("single_c2_v", 64'(cdb_v), 64'(1));
    check("single_c2_robid", 64'(cdb_robid), 64'(5));
    check("single_c2_data", 64'(cdb_data), 64'hDEAD);
    check("single_c2_src", 64'(cdb_src), 64'(2));
    step();
    @(negedge clk);
    check("single_c3_v", 64'(cdb_v), 64'(0));
    check("hold_robid", 64'(cdb_robid), 64'(5));
    check("hold_data", 64'(cdb_data), 64'hDEAD);
    check("hold_src", 64'(cdb_src), 64'(2));

    // Wrap: rr_ptr=3, only buffer 0 loaded; then rr_ptr=1 puts 1 ahead of 0
    step();
    drive(4'b0001);
    exp_src.push_back(2'd0);
    step();
    req_v = '0;
    step();
    @(negedge clk);
    check("wrap_v", 64'(cdb_v), 64'(1));
    check("wrap_src", 64'(cdb_src), 64'(0));
    step();
    drive(4'b0011);
    exp_src.push_back(2'd1);
    exp_src.push_back(2'd0);
    step();
    req_v = '0;
    drain("wrap_drain", 10);

    // Idle flush: ready drops for the flush cycle and rr_ptr returns to 0
    step();
    flush = 1'b1;
    @(negedge clk);
    check("flush_idle_rdy", 64'(req_rdy), 64'(0));
    step();
    flush = 1'b0;

    // Backpressure on requester 1 while the others keep winning
    rem = '{2, 3, 2, 2};
    for (int i = 0; i < N; i++) need_new[i] = 1'b1;
    for (int c = 0; c < 12; c++) begin
      for (int i = 0; i < N; i++) begin
        if (rem[i] > 0) begin
          if (need_new[i]) begin
            req_robid[i] = next_robid;
            req_data[i]  = $urandom;
            next_robid   = next_robid + 5'd1;
            need_new[i]  = 1'b0;
          end
          req_v[i] = 1'b1;
        end else begin
          req_v[i] = 1'b0;
        end
      end
      @(negedge clk);
      if (c == 1) check("bp_rdy1_c1", 64'(req_rdy[1]), 64'(1));
      if (c == 2) check("bp_rdy1_full", 64'(req_rdy[1]), 64'(0));
      if (c == 3) check("bp_rdy1_c3", 64'(req_rdy[1]), 64'(1));
      for (int i = 0; i < N; i++) begin
        if (req_v[i] && req_rdy[i]) begin
          rem[i]--;
          need_new[i] = 1'b1;
        end
      end
      step();
    end
    req_v = '0;
    check("bp_all_sent", 64'(rem[0] + rem[1] + rem[2] + rem[3]), 64'(0));
    drain("bp_drain", 20);

    // Flush with three buffers loaded; rr_ptr is 2 going in
    step();
    drive(4'b1110);
    step();
    drive(4'b1110);
    step();
    flush = 1'b1;
    drive(4'b0001);
    @(negedge clk);
    check("flush_rdy", 64'(req_rdy), 64'(0));
    step();
    flush = 1'b0;
    req_v = '0;
    clear_sb();
    @(negedge clk);
    check("flush_next_v", 64'(cdb_v), 64'(0));
    check("flush_next_rdy", 64'(req_rdy), 64'hF);
    step();
    drive(4'b1010);
    exp_src.push_back(2'd1);
    exp_src.push_back(2'd3);
    step();
    req_v = '0;
    drain("flush_drain", 10);

    // Reset in the middle of a burst
    step();
    drive(4'b1111);
    step();
    drive(4'b1111);
    step();
    req_v = '0;
    rst   = 1'b1;
    step();
    clear_sb();
    bcast_cnt = 0;
    @(negedge clk);
    check("mid_rst_v", 64'(cdb_v), 64'(0));
    check("mid_rst_robid", 64'(cdb_robid), 64'(0));
    check("mid_rst_data", 64'(cdb_data), 64'(0));
    check("mid_rst_src", 64'(cdb_src), 64'(0));
    check("mid_rst_rdy", 64'(req_rdy), 64'(0));
    step();
    rst = 1'b0;
    repeat (10) step();
    @(negedge clk);
    check("post_rst_no_bcast", 64'(bcast_cnt), 64'(0));
    check("post_rst2_rdy", 64'(req_rdy), 64'hF);

    check("end_sb_empty", 64'(sb_empty()), 64'(1));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
